// File: rtl/arcanoid_pkg.sv
// Shared encodings and screen constants for the Arkanoid game sequencer
// and the ball movers that run beside it in the pclk domain.
package arcanoid_pkg;

    localparam int SCREEN_W     = 1024;
    localparam int SCREEN_H     = 768;
    localparam int FLOOR_Y      = 760;
    localparam int LIVES        = 3;
    localparam int LOST_FRAMES  = 90;
    localparam int CLEAR_FRAMES = 60;

    localparam int BRICKS  = 16;
    localparam int Y_W     = 12;
    localparam int SCORE_W = 10;
    localparam int LEVEL_W = 4;
    localparam int LIVES_W = 2;

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    typedef enum logic [2:0] {
        ST_READY = 3'd0,
        ST_PLAY  = 3'd1,
        ST_LOST  = 3'd2,
        ST_CLEAR = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

endpackage

// File: rtl/arcanoid_game_ctl_if.sv
// Game-control bundle between the video/ball datapath (master) and the
// frame-rate game sequencer (slave).
interface arcanoid_game_ctl_if;
    import arcanoid_pkg::*;

    logic               vsync_in;
    logic               mouse_left;
    logic [Y_W-1:0]     y_pos;
    logic [BRICKS-1:0]  blocks_in;

    logic [2:0]         state;
    logic               ball_run;
    logic               ball_hold;
    logic               blocks_reload;
    logic [LIVES_W-1:0] lives;
    logic [SCORE_W-1:0] score;
    logic [LEVEL_W-1:0] level;

    modport master (
        output vsync_in,
        output mouse_left,
        output y_pos,
        output blocks_in,
        input  state,
        input  ball_run,
        input  ball_hold,
        input  blocks_reload,
        input  lives,
        input  score,
        input  level
    );

    modport slave (
        input  vsync_in,
        input  mouse_left,
        input  y_pos,
        input  blocks_in,
        output state,
        output ball_run,
        output ball_hold,
        output blocks_reload,
        output lives,
        output score,
        output level
    );

endinterface

// File: rtl/arcanoid_game_ctl_frame_tick_gen.sv
// Vsync rising-edge detector: one registered tick per video frame.
module frame_tick_gen (
    input  logic clk,
    input  logic rst_n,
    input  logic vsync_in,
    output logic tick
);

    logic vsync_q;
    logic vsync_d;
    logic tick_q;
    logic tick_d;

    always_comb begin
        vsync_d = vsync_in;
        tick_d  = vsync_in & ~vsync_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsync_q <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            vsync_q <= vsync_d;
            tick_q  <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/arcanoid_game_ctl.sv
// Frame-rate game sequencer: ball hold/run/freeze, lives, score, level
// and brick-wall reload, all decided once per video frame.
module arcanoid_game_ctl #(
    parameter int LIVES        = arcanoid_pkg::LIVES,
    parameter int FLOOR_Y      = arcanoid_pkg::FLOOR_Y,
    parameter int LOST_FRAMES  = arcanoid_pkg::LOST_FRAMES,
    parameter int CLEAR_FRAMES = arcanoid_pkg::CLEAR_FRAMES
) (
    input  logic                pclk,
    input  logic                reset,
    arcanoid_game_ctl_if.slave  bus
);

    import arcanoid_pkg::*;

    localparam int CNT_MAX = (LOST_FRAMES > CLEAR_FRAMES) ?
                             LOST_FRAMES : CLEAR_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]   LOST_LAST  = CNT_W'(LOST_FRAMES - 1);
    localparam logic [CNT_W-1:0]   CLEAR_LAST = CNT_W'(CLEAR_FRAMES - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
    localparam logic [Y_W-1:0]     FLOOR      = Y_W'(FLOOR_Y);

    function automatic logic [4:0] popcount16(input logic [BRICKS-1:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < BRICKS; i++) begin
            n = n + 5'(v[i]);
        end
        return n;
    endfunction

    logic tick;

    frame_tick_gen u_tick (
        .clk      (pclk),
        .rst_n    (reset),
        .vsync_in (bus.vsync_in),
        .tick     (tick)
    );

    state_e             state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [LIVES_W-1:0] lives_q,  lives_d;
    logic [SCORE_W-1:0] score_q,  score_d;
    logic [LEVEL_W-1:0] level_q,  level_d;
    logic [BRICKS-1:0]  prev_q,   prev_d;
    logic               reload_q, reload_d;
    logic               click_q,  click_d;
    logic               mouse_q,  mouse_d;

    logic               click_rise;
    logic [4:0]         gained;
    logic [SCORE_W:0]   score_sum;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lives_d  = lives_q;
        score_d  = score_q;
        level_d  = level_q;
        prev_d   = prev_q;
        reload_d = 1'b0;
        mouse_d  = bus.mouse_left;

        // An edge landing on the tick cycle survives to the next tick.
        click_rise = bus.mouse_left & ~mouse_q;
        click_d    = click_rise | (click_q & ~tick);

        gained    = popcount16(prev_q & ~bus.blocks_in);
        score_sum = {1'b0, score_q} + (SCORE_W + 1)'(gained);

        if (tick) begin
            prev_d = bus.blocks_in;
        end

        case (state_q)
            ST_READY: begin
                if (tick && click_q && lives_q != '0) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (tick) begin
                    if (score_sum > {1'b0, SCORE_MAX}) begin
                        score_d = SCORE_MAX;
                    end else begin
                        score_d = score_sum[SCORE_W-1:0];
                    end
                    // A cleared wall wins over a ball lost in the same frame.
                    if (bus.blocks_in == '0) begin
                        state_d = ST_CLEAR;
                        cnt_d   = '0;
                    end else if (bus.y_pos >= FLOOR) begin
                        state_d = ST_LOST;
                        cnt_d   = '0;
                        if (lives_q != '0) begin
                            lives_d = lives_q - LIVES_W'(1);
                        end
                    end
                end
            end
            ST_LOST: begin
                if (tick) begin
                    if (cnt_q == LOST_LAST) begin
                        cnt_d   = '0;
                        state_d = (lives_q == '0) ? ST_OVER : ST_READY;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            ST_CLEAR: begin
                if (tick) begin
                    if (cnt_q == CLEAR_LAST) begin
                        cnt_d    = '0;
                        state_d  = ST_READY;
                        level_d  = level_q + LEVEL_W'(1);
                        reload_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            ST_OVER: begin
                if (tick && click_q) begin
                    state_d  = ST_READY;
                    lives_d  = LIVES_INIT;
                    score_d  = '0;
                    level_d  = '0;
                    reload_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_READY;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!reset) begin
            state_q  <= ST_READY;
            cnt_q    <= '0;
            lives_q  <= LIVES_INIT;
            score_q  <= '0;
            level_q  <= '0;
            prev_q   <= '1;
            reload_q <= 1'b0;
            click_q  <= 1'b0;
            mouse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lives_q  <= lives_d;
            score_q  <= score_d;
            level_q  <= level_d;
            prev_q   <= prev_d;
            reload_q <= reload_d;
            click_q  <= click_d;
            mouse_q  <= mouse_d;
        end
    end

    assign bus.state         = state_q;
    assign bus.ball_run      = (state_q == ST_PLAY);
    assign bus.ball_hold     = (state_q == ST_READY);
    assign bus.blocks_reload = reload_q;
    assign bus.lives         = lives_q;
    assign bus.score         = score_q;
    assign bus.level         = level_q;

endmodule

// File: tb/tb_arcanoid_game_ctl.sv
// Scoreboard bench for arcanoid_game_ctl: frame-level reference model
// feeds a queue, a monitor checks the DUT after every tick or reset.
module tb_arcanoid_game_ctl;

    localparam int FRAME   = 8;
    localparam int N_LIVES = 3;
    localparam int FLOOR   = 760;
    localparam int N_LOST  = 90;
    localparam int N_CLEAR = 60;

    localparam int S_READY = 0;
    localparam int S_PLAY  = 1;
    localparam int S_LOST  = 2;
    localparam int S_CLEAR = 3;
    localparam int S_OVER  = 4;

    typedef struct {
        int st;
        int run;
        int hold;
        int rel;
        int lives;
        int score;
        int level;
    } exp_t;

    logic pclk  = 1'b0;
    logic reset = 1'b0;

    arcanoid_game_ctl_if bus ();

    arcanoid_game_ctl #(
        .LIVES        (N_LIVES),
        .FLOOR_Y      (FLOOR),
        .LOST_FRAMES  (N_LOST),
        .CLEAR_FRAMES (N_CLEAR)
    ) dut (
        .pclk  (pclk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 pclk = ~pclk;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    int          m_st;
    int          m_lives;
    int          m_score;
    int          m_level;
    int          m_rem;
    int          m_rel;
    bit          m_click;
    logic [15:0] m_prev;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t",
                     nm, act, req, $time);
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.st    = m_st;
        e.run   = (m_st == S_PLAY) ? 1 : 0;
        e.hold  = (m_st == S_READY) ? 1 : 0;
        e.rel   = m_rel;
        e.lives = m_lives;
        e.score = m_score;
        e.level = m_level;
        sb.push_back(e);
    endtask

    task automatic model_reset();
        m_st    = S_READY;
        m_lives = N_LIVES;
        m_score = 0;
        m_level = 0;
        m_rem   = 0;
        m_rel   = 0;
        m_click = 1'b0;
        m_prev  = 16'hFFFF;
    endtask

    // One frame of game rules, applied at the tick.
    task automatic model_tick(input int y, input logic [15:0] b);
        m_rel = 0;
        case (m_st)
            S_READY: if (m_click) m_st = S_PLAY;
            S_PLAY: begin
                m_score = m_score + $countones(m_prev & ~b);
                if (m_score > 1023) m_score = 1023;
                if (b == 16'h0000) begin
                    m_st  = S_CLEAR;
                    m_rem = N_CLEAR;
                end else if (y >= FLOOR) begin
                    m_st    = S_LOST;
                    m_rem   = N_LOST;
                    m_lives = m_lives - 1;
                end
            end
            S_LOST: begin
                m_rem = m_rem - 1;
                if (m_rem == 0) m_st = (m_lives == 0) ? S_OVER : S_READY;
            end
            S_CLEAR: begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    m_st    = S_READY;
                    m_rel   = 1;
                    m_level = (m_level + 1) % 16;
                end
            end
            default: begin
                if (m_click) begin
                    m_st    = S_READY;
                    m_lives = N_LIVES;
                    m_score = 0;
                    m_level = 0;
                    m_rel   = 1;
                end
            end
        endcase
        m_prev  = b;
        m_click = 1'b0;
    endtask

    // Entered and left just after a posedge; click_at is the cycle of the
    // mouse rising edge inside the frame (1 = the tick cycle), -1 = none.
    task automatic frame(input int y, input logic [15:0] b, input int click_at);
        bus.y_pos     = 12'(y);
        bus.blocks_in = b;
        bus.vsync_in  = 1'b1;
        model_tick(y, b);
        push_exp();
        if (click_at >= 0) m_click = 1'b1;
        for (int c = 1; c < FRAME; c++) begin
            @(posedge pclk);
            #1;
            if (c == 2) bus.vsync_in = 1'b0;
            if (c == click_at) bus.mouse_left = 1'b1;
            if (c == click_at + 2) bus.mouse_left = 1'b0;
        end
        @(posedge pclk);
        #1;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            model_reset();
            push_exp();
        end
        bus.vsync_in   = 1'b0;
        bus.mouse_left = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < n; i++) @(posedge pclk);
        #1;
        reset = 1'b1;
    endtask

    logic h1 = 1'b0;
    logic h2 = 1'b0;
    logic rs;
    logic due;

    initial begin
        exp_t e;
        forever begin
            @(posedge pclk);
            rs  = reset;
            due = h1 & ~h2;
            h2  = h1;
            h1  = bus.vsync_in;
            #1;
            if (!rs || due) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_empty actual=0 required=1 t=%0t", $time);
                end else begin
                    e = sb.pop_front();
                    chk("state",  32'(bus.state),         32'(e.st));
                    chk("run",    32'(bus.ball_run),      32'(e.run));
                    chk("hold",   32'(bus.ball_hold),     32'(e.hold));
                    chk("reload", 32'(bus.blocks_reload), 32'(e.rel));
                    chk("lives",  32'(bus.lives),         32'(e.lives));
                    chk("score",  32'(bus.score),         32'(e.score));
                    chk("level",  32'(bus.level),         32'(e.level));
                end
            end else begin
                chk("reload_idle", 32'(bus.blocks_reload), 32'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] mask;
        logic [15:0] rb;
        int          k;
        int          y;
        int          ca;

        bus.vsync_in   = 1'b0;
        bus.mouse_left = 1'b0;
        bus.y_pos      = 12'd100;
        bus.blocks_in  = 16'hFFFF;
        model_reset();
        do_reset(2);

        repeat (3) frame(100, 16'hFFFF, -1);
        frame(100, 16'hFFFF, 3);
        frame(100, 16'hFFFF, -1);
        frame(100, 16'hFFFC, -1);

        frame(760, 16'hFFFC, -1);
        for (int i = 0; i < N_LOST; i++) begin
            frame(100, 16'hFFFC, (i == 10 || i == N_LOST - 2) ? 3 : -1);
        end
        frame(100, 16'hFFFC, -1);

        frame(100, 16'hFFFF, 3);
        frame(100, 16'hFFFF, -1);
        frame(800, 16'h0000, -1);
        for (int i = 0; i < N_CLEAR; i++) frame(100, 16'hFFFF, -1);

        frame(100, 16'hFFFF, 1);
        frame(100, 16'hFFFF, -1);
        while (m_score < 1022) begin
            k    = (1022 - m_score > 15) ? 15 : 1022 - m_score;
            mask = 16'hFFFF;
            mask = mask << k;
            frame(100, mask, -1);
            frame(100, 16'hFFFF, -1);
        end
        frame(100, 16'hFFF0, -1);
        frame(100, 16'h0FF0, -1);

        frame(760, 16'hFFFF, -1);
        for (int i = 0; i < N_LOST; i++) frame(100, 16'hFFFF, -1);
        frame(100, 16'hFFFF, 3);
        frame(100, 16'hFFFF, -1);
        frame(770, 16'hFFFF, -1);
        for (int i = 0; i < N_LOST; i++) frame(100, 16'hFFFF, -1);
        frame(100, 16'hFFFF, -1);
        frame(100, 16'hFFFF, 3);
        frame(100, 16'hFFFF, -1);
        frame(100, 16'hFFFF, -1);

        frame(100, 16'hFFFF, 3);
        frame(100, 16'hFFFF, -1);
        frame(900, 16'hFFFF, -1);
        for (int i = 0; i < 20; i++) frame(100, 16'hFFFF, -1);
        repeat (3) @(posedge pclk);
        #1;
        do_reset(1);
        repeat (3) frame(100, 16'hFFFF, -1);

        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 19) == 0) y = int'($urandom_range(760, 1023));
            else y = int'($urandom_range(0, 759));
            case ($urandom_range(0, 5))
                0:       rb = 16'hFFFF;
                1:       rb = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'h8001;
                2, 3:    rb = m_prev & 16'($urandom());
                default: rb = 16'($urandom());
            endcase
            if ($urandom_range(0, 3) == 0) ca = ($urandom_range(0, 1) == 0) ? 1 : 3;
            else ca = -1;
            frame(y, rb, ca);
            if ($urandom_range(0, 299) == 0) do_reset(int'($urandom_range(1, 2)));
        end

        repeat (4) @(posedge pclk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
